dcache_mem_arb: RTL
===================

DCACHE_MEM_ARB -- requirements
Module: dcache_mem_arb

Interface
- REQ-001 SHALL have parameter ADDR_W, default 32, memory byte address width.
- REQ-002 SHALL have parameter BEAT_W, default 128, width of one line beat; dcache_blocking_pkg::ram_dat_dat_t width.
- REQ-003 SHALL have parameter BEATS, default 4, beats per line (power of two, >=2).
- REQ-004 clk  in  1  single clock; all state on rising edge.
- REQ-005 rst  in  1  reset, asynchronous, active-high.
- REQ-006 req_valid  in  2  per-requester request/beat valid; bit 0 dcache, bit 1 second client.
- REQ-007 req_wrbk  in  2  per-requester: 1 = writeback burst, 0 = line fill.
- REQ-008 req_addr  in  2*ADDR_W  per-requester line address, slice i = requester i.
- REQ-009 req_wdat  in  2*BEAT_W  per-requester writeback beat data.
- REQ-010 req_accept  out  2  combinational; request/beat of requester i taken this cycle.
- REQ-011 arb__mem_valid_r  out  1  command strobe, one cycle per transaction.
- REQ-012 arb__mem_wrbk_r  out  1  command type, qualified by arb__mem_valid_r.
- REQ-013 arb__mem_addr_r  out  ADDR_W  command address.
- REQ-014 arb__mem_dat_valid_r / arb__mem_sop_r / arb__mem_eop_r  out  1 each  writeback beat valid, first beat, last beat.
- REQ-015 arb__mem_dat_r  out  BEAT_W  writeback beat data.
- REQ-016 mem__arb_valid_w / mem__arb_sop_w / mem__arb_eop_w  in  1 each  fill response beat valid, first, last.
- REQ-017 mem__arb_data_w  in  BEAT_W  fill response data.
- REQ-018 rsp_valid_r  out  2  fill beat valid, one-hot to owning requester.
- REQ-019 rsp_sop_r / rsp_eop_r  out  1 each  registered copy of response sop/eop.
- REQ-020 rsp_data_r  out  BEAT_W  registered response data, shared by both requesters.

Function
- REQ-021 SHALL implement states IDLE, WRBK, FILL plus a 1-bit owner register and 1-bit last-grant pointer.
- REQ-022 In IDLE with exactly one req_valid set, SHALL grant that requester; with both set, SHALL grant the one not equal to last-grant; grant updates owner and last-grant.
- REQ-023 Grant cycle SHALL assert req_accept[owner] for one cycle; req_addr/req_wrbk SHALL be sampled that cycle; memory side has no backpressure.
- REQ-024 Fill grant: next cycle arb__mem_valid_r=1, wrbk_r=0, addr_r=sampled address; state -> FILL.
- REQ-025 In FILL each mem__arb_valid_w beat at cycle M SHALL appear at M+1 on rsp_valid_r[owner] with sop/eop/data; eop beat returns state to IDLE at M+1; no new grant before then.
- REQ-026 Writeback grant: grant cycle is also beat 0; next cycle arb__mem_valid_r=1, wrbk_r=1, addr_r, dat_valid_r=1, sop_r=1, dat_r=req_wdat[owner]; state -> WRBK.
- REQ-027 In WRBK, req_accept[owner]=req_valid[owner]; each accepted beat SHALL appear one cycle later with dat_valid_r=1; deasserted req_valid SHALL give a bubble (dat_valid_r=0), not abort.
- REQ-028 Beat counter (log2 BEATS bits) SHALL count accepted beats; beat BEATS-1 SHALL carry eop_r=1 and return state to IDLE at the same edge; wrap to 0.
- REQ-029 req_accept for the non-owner SHALL be 0 outside IDLE grant; its request waits, held stable by the requester.
- REQ-030 mem__arb_valid_w outside FILL SHALL be ignored (rsp_valid_r stays 0).
- REQ-031 arb__mem_valid_r, dat_valid_r, sop_r, eop_r, rsp_valid_r SHALL be single-cycle strobes, 0 when not driven by a rule above.
- REQ-032 Back-to-back: grant SHALL be possible in the cycle state returns to IDLE (zero dead cycles after eop).

Reset
- REQ-033 rst SHALL asynchronously force IDLE, counter 0, owner 0, last-grant 1 (requester 0 wins first tie), all outputs 0, including mid-burst; an interrupted transaction is abandoned.

Verification
- REQ-034 Reset, then req_valid=2'b11 both fills, addr0=0x100, addr1=0x200 -> accept 2'b01, mem cmd 0x100; after 4-beat response, accept 2'b10, cmd 0x200.
- REQ-035 Requester 1 writeback addr 0x340, beats A0..A3 with a 1-cycle gap after A1 -> dat_valid_r pattern 1,1,0,1,1; sop on A0, eop on A3, wrbk_r=1 with addr 0x340 on A0 only.
- REQ-036 Fill by requester 0, response D0..D3 at cycles M..M+3 -> rsp_valid_r=2'b01 at M+1..M+4, eop_r at M+4, rsp_valid_r[1] never set.
- REQ-037 Spurious mem__arb_valid_w=1 in IDLE -> rsp_valid_r stays 2'b00, state stays IDLE.
- REQ-038 rst asserted after beat 2 of a writeback -> all outputs 0 immediately; after release, pending req_valid=2'b10 granted first cycle, sop_r=1 on its beat 0.

Source files
------------

// File: rtl/dcache_mem_arb.sv
// dcache_mem_arb: arbitrates two requesters (dcache on port 0, a second
// client on port 1) onto one memory command/beat channel. Each transaction
// is either a line fill (one command, BEATS response beats routed back to
// the owner) or a writeback burst (command plus BEATS data beats).
//
// Handshake: a requester raises req_valid[i] and holds its inputs stable
// until req_accept[i] is seen high in the same cycle; req_accept is
// combinational and marks the cycle in which the request/beat is taken.
// Outputs toward memory and back to the requesters are registered strobes
// with no backpressure.
module dcache_mem_arb #(
   parameter int ADDR_W = 32,
   parameter int BEAT_W = 128,
   parameter int BEATS  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            req_valid,
   input  logic [1:0]            req_wrbk,
   input  logic [2*ADDR_W-1:0]   req_addr,
   input  logic [2*BEAT_W-1:0]   req_wdat,
   output logic [1:0]            req_accept,
   output logic                  arb__mem_valid_r,
   output logic                  arb__mem_wrbk_r,
   output logic [ADDR_W-1:0]     arb__mem_addr_r,
   output logic                  arb__mem_dat_valid_r,
   output logic                  arb__mem_sop_r,
   output logic                  arb__mem_eop_r,
   output logic [BEAT_W-1:0]     arb__mem_dat_r,
   input  logic                  mem__arb_valid_w,
   input  logic                  mem__arb_sop_w,
   input  logic                  mem__arb_eop_w,
   input  logic [BEAT_W-1:0]     mem__arb_data_w,
   output logic [1:0]            rsp_valid_r,
   output logic                  rsp_sop_r,
   output logic                  rsp_eop_r,
   output logic [BEAT_W-1:0]     rsp_data_r,
   output logic [1:0]            dbg_state
);

   localparam int CNT_W = $clog2(BEATS);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WRBK = 2'd1,
      ST_FILL = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                owner_q, owner_d;
   logic                last_q, last_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                mem_valid_q, mem_valid_d;
   logic                mem_wrbk_q, mem_wrbk_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic                mem_dat_valid_q, mem_dat_valid_d;
   logic                mem_sop_q, mem_sop_d;
   logic                mem_eop_q, mem_eop_d;
   logic [BEAT_W-1:0]   mem_dat_q, mem_dat_d;
   logic [1:0]          rsp_valid_q, rsp_valid_d;
   logic                rsp_sop_q, rsp_sop_d;
   logic                rsp_eop_q, rsp_eop_d;
   logic [BEAT_W-1:0]   rsp_data_q, rsp_data_d;
   logic [1:0]          accept_d;

   logic                gnt;
   logic                sel;
   logic [ADDR_W-1:0]   sel_addr;
   logic [BEAT_W-1:0]   sel_wdat;
   logic                sel_wrbk;
   logic                sel_valid;

   // Round-robin pick in IDLE; otherwise the current owner drives the inputs.
   always_comb begin
      gnt = req_valid[1];
      if (req_valid == 2'b11) gnt = ~last_q;
      sel = (state_q == ST_IDLE) ? gnt : owner_q;
   end

   assign sel_addr  = sel ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
   assign sel_wdat  = sel ? req_wdat[2*BEAT_W-1:BEAT_W] : req_wdat[BEAT_W-1:0];
   assign sel_wrbk  = req_wrbk[sel];
   assign sel_valid = req_valid[sel];

   // Next-state, accept and registered-output computation for the arbiter FSM.
   always_comb begin
      state_d         = state_q;
      owner_d         = owner_q;
      last_d          = last_q;
      cnt_d           = cnt_q;
      mem_valid_d     = 1'b0;
      mem_wrbk_d      = mem_wrbk_q;
      mem_addr_d      = mem_addr_q;
      mem_dat_valid_d = 1'b0;
      mem_sop_d       = 1'b0;
      mem_eop_d       = 1'b0;
      mem_dat_d       = mem_dat_q;
      rsp_valid_d     = 2'b00;
      rsp_sop_d       = 1'b0;
      rsp_eop_d       = 1'b0;
      rsp_data_d      = rsp_data_q;
      accept_d        = 2'b00;
      case (state_q)
         ST_IDLE: begin
            if (|req_valid) begin
               accept_d[gnt] = 1'b1;
               owner_d       = gnt;
               last_d        = gnt;
               mem_valid_d   = 1'b1;
               mem_wrbk_d    = sel_wrbk;
               mem_addr_d    = sel_addr;
               if (sel_wrbk) begin
                  // The grant cycle also carries writeback beat 0.
                  mem_dat_valid_d = 1'b1;
                  mem_sop_d       = 1'b1;
                  mem_dat_d       = sel_wdat;
                  cnt_d           = CNT_W'(1);
                  state_d         = ST_WRBK;
               end else begin
                  state_d = ST_FILL;
               end
            end
         end
         ST_WRBK: begin
            // A dropped req_valid is a bubble; the burst simply waits.
            if (sel_valid) begin
               accept_d[owner_q] = 1'b1;
               mem_dat_valid_d   = 1'b1;
               mem_dat_d         = sel_wdat;
               cnt_d             = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(BEATS - 1)) begin
                  mem_eop_d = 1'b1;
                  state_d   = ST_IDLE;
               end
            end
         end
         ST_FILL: begin
            if (mem__arb_valid_w) begin
               rsp_valid_d[owner_q] = 1'b1;
               rsp_sop_d            = mem__arb_sop_w;
               rsp_eop_d            = mem__arb_eop_w;
               rsp_data_d           = mem__arb_data_w;
               if (mem__arb_eop_w) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Accept is forced low while reset is held so nothing is taken mid-reset.
   assign req_accept = rst ? 2'b00 : accept_d;

   // State and registered outputs; reset abandons any transaction in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         owner_q         <= 1'b0;
         last_q          <= 1'b1;
         cnt_q           <= '0;
         mem_valid_q     <= 1'b0;
         mem_wrbk_q      <= 1'b0;
         mem_addr_q      <= '0;
         mem_dat_valid_q <= 1'b0;
         mem_sop_q       <= 1'b0;
         mem_eop_q       <= 1'b0;
         mem_dat_q       <= '0;
         rsp_valid_q     <= 2'b00;
         rsp_sop_q       <= 1'b0;
         rsp_eop_q       <= 1'b0;
         rsp_data_q      <= '0;
      end else begin
         state_q         <= state_d;
         owner_q         <= owner_d;
         last_q          <= last_d;
         cnt_q           <= cnt_d;
         mem_valid_q     <= mem_valid_d;
         mem_wrbk_q      <= mem_wrbk_d;
         mem_addr_q      <= mem_addr_d;
         mem_dat_valid_q <= mem_dat_valid_d;
         mem_sop_q       <= mem_sop_d;
         mem_eop_q       <= mem_eop_d;
         mem_dat_q       <= mem_dat_d;
         rsp_valid_q     <= rsp_valid_d;
         rsp_sop_q       <= rsp_sop_d;
         rsp_eop_q       <= rsp_eop_d;
         rsp_data_q      <= rsp_data_d;
      end
   end

   assign arb__mem_valid_r     = mem_valid_q;
   assign arb__mem_wrbk_r      = mem_wrbk_q;
   assign arb__mem_addr_r      = mem_addr_q;
   assign arb__mem_dat_valid_r = mem_dat_valid_q;
   assign arb__mem_sop_r       = mem_sop_q;
   assign arb__mem_eop_r       = mem_eop_q;
   assign arb__mem_dat_r       = mem_dat_q;
   assign rsp_valid_r          = rsp_valid_q;
   assign rsp_sop_r            = rsp_sop_q;
   assign rsp_eop_r            = rsp_eop_q;
   assign rsp_data_r           = rsp_data_q;
   assign dbg_state            = state_q;

endmodule
